g_minus_rb_gen: RTL

//  Streaming colour-difference generator for the CFA pipeline. Takes a co-sited G and R/B pixel

---
 rtl/g_minus_rb_gen.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/g_minus_rb_gen.sv
// rtl/g_minus_rb_gen.sv - two-stage saturated G-RB colour-difference generator with line column tracking.
// Optional GMRB_SATCNT_EN adds a saturating sat_count output cleared on accepted in_sof.
module g_minus_rb_gen #(
  parameter int PixelBitWidth = 12,
  parameter int LineWidth     = 1920,
  parameter int ColBits       = 11
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_sof,
  input  logic [PixelBitWidth-1:0]   g,
  input  logic [PixelBitWidth-1:0]   rb,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PixelBitWidth-3:0]   g_m_rb,
  output logic                       out_sat,
  output logic                       out_eol
`ifdef GMRB_SATCNT_EN
  ,
  output logic [15:0]                sat_count
`endif
);

  localparam int W1       = PixelBitWidth + 1;
  localparam int OW       = PixelBitWidth - 2;
  localparam int SAT_HI_I = 2**(PixelBitWidth-3) - 1;
  localparam int SAT_LO_I = -(2**(PixelBitWidth-3));
  localparam logic signed [PixelBitWidth:0] SAT_HI = W1'(SAT_HI_I);
  localparam logic signed [PixelBitWidth:0] SAT_LO = W1'(SAT_LO_I);
  localparam logic [OW-1:0] OUT_HI = {1'b0, {(OW-1){1'b1}}};
  localparam logic [OW-1:0] OUT_LO = {1'b1, {(OW-1){1'b0}}};
  localparam logic [ColBits-1:0] LAST_COL = ColBits'(LineWidth - 1);

  logic                   adv;
  logic                   accept;
  logic [ColBits-1:0]     pair_col;
  logic                   pair_eol;

  logic                   s1_valid_q, s1_valid_d;
  logic [PixelBitWidth:0] s1_diff_q, s1_diff_d;
  logic                   s1_eol_q, s1_eol_d;
  logic                   s2_valid_q, s2_valid_d;
  logic [OW-1:0]          g_m_rb_q, g_m_rb_d;
  logic                   sat_q, sat_d;
  logic                   eol_q, eol_d;
  logic [ColBits-1:0]     col_q, col_d;

  always_comb begin
    adv        = !(s2_valid_q && !out_ready);
    accept     = in_valid && adv;
    // An accepted start-of-frame pair is column 0 regardless of where the counter was.
    pair_col   = in_sof ? '0 : col_q;
    pair_eol   = (pair_col == LAST_COL);

    s1_valid_d = s1_valid_q;
    s1_diff_d  = s1_diff_q;
    s1_eol_d   = s1_eol_q;
    s2_valid_d = s2_valid_q;
    g_m_rb_d   = g_m_rb_q;
    sat_d      = sat_q;
    eol_d      = eol_q;
    col_d      = col_q;

    if (accept) begin
      col_d = pair_eol ? '0 : pair_col + 1'b1;
    end

    if (adv) begin
      s1_valid_d = in_valid;
      s1_diff_d  = {1'b0, g} - {1'b0, rb};
      s1_eol_d   = accept && pair_eol;
      s2_valid_d = s1_valid_q;
      eol_d      = s1_eol_q;
      if ($signed(s1_diff_q) > SAT_HI) begin
        g_m_rb_d = OUT_HI;
        sat_d    = 1'b1;
      end else if ($signed(s1_diff_q) < SAT_LO) begin
        g_m_rb_d = OUT_LO;
        sat_d    = 1'b1;
      end else begin
        g_m_rb_d = s1_diff_q[OW-1:0];
        sat_d    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_diff_q  <= '0;
      s1_eol_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      g_m_rb_q   <= '0;
      sat_q      <= 1'b0;
      eol_q      <= 1'b0;
      col_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_diff_q  <= s1_diff_d;
      s1_eol_q   <= s1_eol_d;
      s2_valid_q <= s2_valid_d;
      g_m_rb_q   <= g_m_rb_d;
      sat_q      <= sat_d;
      eol_q      <= eol_d;
      col_q      <= col_d;
    end
  end

  assign in_ready  = adv;
  assign out_valid = s2_valid_q;
  assign g_m_rb    = g_m_rb_q;
  assign out_sat   = sat_q;
  assign out_eol   = eol_q;

`ifdef GMRB_SATCNT_EN
  logic [15:0] sat_cnt_q, sat_cnt_d;

  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (accept && in_sof) begin
      sat_cnt_d = '0;
    end else if (s2_valid_q && out_ready && sat_q && (sat_cnt_q != 16'hFFFF)) begin
      sat_cnt_d = sat_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sat_cnt_q <= '0;
    end else begin
      sat_cnt_q <= sat_cnt_d;
    end
  end

  assign sat_count = sat_cnt_q;
`else
  // Saturation counter not built; outputs above are the complete interface.
`endif

endmodule
